parking_gate_ctrl: RTL and testbench
====================================

# parking_gate_ctrl

Gate-side controller that produces the car event stream the parking occupancy counter consumes. It runs two independent gate state machines, one for entry and one for exit. Each machine debounces the arrival and pass sensors, checks occupancy and vacancy feedback from the counter, and drives a barrier. It emits one-cycle `car_entered`/`car_exited` pulses with their university flag, and only when a car physically passes.

## Interface

Parameters:

- `DEBOUNCE`, 4: consecutive high samples required before a sensor counts as asserted (≥2).
- `OPEN_TIMEOUT`, 200: cycles the barrier stays open waiting for a pass before closing.
- `CLOSE_HOLD`, 8: cycles after closing during which new arrivals are not accepted.

Ports (clock and reset first):

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state and outputs.
- `car_at_entry`  in  1  entry loop detector, car waiting.
- `uni_badge_entry`  in  1  university badge read at entry, valid while `car_at_entry`.
- `pass_entry`  in  1  entry pass sensor beyond barrier.
- `car_at_exit`  in  1  exit loop detector.
- `uni_badge_exit`  in  1  university badge at exit.
- `pass_exit`  in  1  exit pass sensor.
- `uni_is_vacated_space`  in  1  counter feedback, uni space free.
- `is_vacated_space`  in  1  counter feedback, free space available.
- `uni_parked_car`  in  9  counter feedback, uni cars parked.
- `parked_car`  in  9  counter feedback, free cars parked.
- `car_entered`  out  1  one-cycle pulse, car passed entry.
- `is_uni_car_entered`  out  1  class of entering car; valid with the pulse, 0 otherwise.
- `car_exited`  out  1  one-cycle pulse, car passed exit.
- `is_uni_car_exited`  out  1  class of exiting car; valid with the pulse, 0 otherwise.
- `barrier_entry`  out  1  1 = entry barrier open.
- `barrier_exit`  out  1  1 = exit barrier open.
- `deny_entry`  out  1  one-cycle pulse, entry refused.
- `deny_exit`  out  1  one-cycle pulse, exit refused.

## Operation

**Debouncers.** Each of the four sensors has a saturating counter of ⌈log2(DEBOUNCE+1)⌉ bits.
- Each high sample increments the counter; a low sample clears it to 0.
- The debounced output is 1 while the count equals `DEBOUNCE`.
- The pass debouncers also produce a rise flag: a one-cycle pulse when the debounced output goes from 0 to 1.

**Entry FSM.** States: IDLE, CHECK, OPEN, DENY, HOLD.
- IDLE: when the debounced arrival is 1, go to CHECK.
- CHECK (one cycle): latch `uni_badge_entry` into the class register.
  - Uni class: grant if `uni_is_vacated_space` = 1.
  - Free class: grant if `is_vacated_space` = 1.
  - Grant → OPEN, clear the timer. Refuse → DENY, pulse `deny_entry`.
- OPEN: `barrier_entry` = 1 and the timer increments each cycle.
  - Pass rise flag → pulse `car_entered` with `is_uni_car_entered` = latched class, then go to HOLD.
  - Timer reaching `OPEN_TIMEOUT` with no pass → HOLD, no pulse.
- DENY: wait until the debounced arrival is 0, then go to IDLE. The same car is refused only once.
- HOLD: barrier low for `CLOSE_HOLD` cycles, then IDLE. Arrivals are ignored during HOLD.

**Exit FSM.** Same states and timing as the entry FSM, with a different grant check.
- Uni class: grant if `uni_parked_car` ≠ 0.
- Free class: grant if `parked_car` ≠ 0.
- Refusal pulses `deny_exit`.

**Independence.** The two FSMs share no state, so `car_entered` and `car_exited` may pulse in the same cycle. A pass sensor asserting outside OPEN is ignored.

## Timing

- Reset (`reset` = 0) takes effect asynchronously.
  - Every output goes to 0 immediately and the barriers drop.
  - Both FSMs return to IDLE; counters, timers and class registers clear.
- The first rising edge with `reset` = 1 resumes normal sampling.
- Edge numbering: edge 1 is the first edge that samples a sensor high, with the sensor continuously high afterwards.
  - Debounced output is 1 after edge `DEBOUNCE`.
  - CHECK is entered at edge `DEBOUNCE`+1.
  - `barrier_*` or `deny_*` becomes 1 after edge `DEBOUNCE`+2.
- Pass rise flag appears `DEBOUNCE` edges after the pass sensor is first sampled high. The event pulse is registered and lasts exactly one cycle starting the next edge. The barrier drops on that same edge.
- Timeout: the barrier is high for exactly `OPEN_TIMEOUT` cycles when no pass occurs.
- Vacancy and occupancy inputs are sampled only in CHECK; changes during OPEN do not revoke a grant.
- Badge inputs are sampled only in CHECK.
- Timer width is ⌈log2(OPEN_TIMEOUT+1)⌉ bits and does not wrap; it stops in HOLD.

## Test plan

Parameters for all scenarios: DEBOUNCE=4, OPEN_TIMEOUT=200, CLOSE_HOLD=8.

1. Hold `reset` = 0 with all sensors high → every output stays 0. Release reset → `barrier_entry` rises 6 edges after release.
2. Free entry: `is_vacated_space` = 1, `car_at_entry` held high → `barrier_entry` = 1 after edge 6. Raise `pass_entry` → `car_entered` = 1 for exactly one cycle with `is_uni_car_entered` = 0, and the barrier drops. A new arrival during the next 8 cycles gets no response.
3. Uni entry refused: `uni_badge_entry` = 1, `uni_is_vacated_space` = 0 → `deny_entry` is a one-cycle pulse after edge 6, and the barrier stays 0. Keeping the arrival high gives no second deny; dropping it and re-arriving gives a new deny.
4. Timeout: grant with no pass → barrier high for exactly 200 cycles, then low with no `car_entered`. An exit attempt with `uni_parked_car` = 0 and a uni badge → `deny_exit` pulse.
5. Glitches: arrival high for 3 cycles, and pass high for 3 cycles while OPEN → no state change and no pulses.
6. Concurrency and reset: entry and exit pass rises in the same cycle → `car_entered` and `car_exited` pulse in the same cycle with their correct classes. Asserting `reset` mid-OPEN → barriers drop immediately with no event pulse.

Source files
------------

// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl
//   Gate-side controller feeding the parking occupancy counter. Two
//   independent gate machines (entry and exit) debounce their arrival and
//   pass sensors, check counter feedback, drive a barrier and emit car events.
//
// Ports
//   clk                   single clock, rising edge
//   reset                 asynchronous, active-low; clears all state/outputs
//   car_at_entry          entry loop detector
//   uni_badge_entry       university badge at entry (sampled in CHECK)
//   pass_entry            entry pass sensor beyond barrier
//   car_at_exit           exit loop detector
//   uni_badge_exit        university badge at exit (sampled in CHECK)
//   pass_exit             exit pass sensor
//   uni_is_vacated_space  counter feedback, uni space free
//   is_vacated_space      counter feedback, free space available
//   uni_parked_car [8:0]  counter feedback, uni cars parked
//   parked_car     [8:0]  counter feedback, free cars parked
//   car_entered / is_uni_car_entered   entry event pulse + class
//   car_exited  / is_uni_car_exited    exit event pulse + class
//   barrier_entry / barrier_exit       1 = barrier open
//   deny_entry / deny_exit             one-cycle refusal pulses
//
// Event semantics: car_entered, car_exited, deny_entry and deny_exit are
// single-cycle registered strobes with no back-pressure; the consumer must
// take them the cycle they are high. The is_uni_* class bits are only
// meaningful (and only nonzero) while their strobe is high.

// Saturating debouncer: level is 1 once DEBOUNCE consecutive high samples
// have been seen, any low sample restarts the count.
module parking_gate_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sample,
  output logic level
);
  localparam int CW = $clog2(DEBOUNCE + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!sample) begin
      cnt <= '0;
    end else if (cnt != CW'(DEBOUNCE)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign level = (cnt == CW'(DEBOUNCE));
endmodule

// One gate machine. The grant decision is supplied by the parent as two
// class-specific permissions, so entry and exit share this code.
module parking_gate_fsm #(
  parameter int OPEN_TIMEOUT = 200,
  parameter int CLOSE_HOLD   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic arrive,      // debounced arrival
  input  logic pass_rise,   // one-cycle debounced pass rise
  input  logic badge,       // raw badge, latched in CHECK
  input  logic grant_uni,   // permission for a uni car
  input  logic grant_free,  // permission for a free car
  output logic barrier,
  output logic event_pulse,
  output logic event_uni,
  output logic deny
);
  localparam int TW = $clog2(OPEN_TIMEOUT + 1);
  localparam int HW = $clog2(CLOSE_HOLD + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_OPEN,
    S_DENY,
    S_HOLD
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] timer;
  logic [HW-1:0] hold_cnt;
  logic          cls;
  logic          granted;
  logic          event_nxt;
  logic          deny_nxt;

  // Decision uses the live badge because the class register is loaded on
  // the same edge that leaves CHECK.
  assign granted = badge ? grant_uni : grant_free;

  always_comb begin
    state_nxt = state;
    event_nxt = 1'b0;
    deny_nxt  = 1'b0;
    case (state)
      S_IDLE:  if (arrive) state_nxt = S_CHECK;
      S_CHECK: begin
        if (granted) begin
          state_nxt = S_OPEN;
        end else begin
          state_nxt = S_DENY;
          deny_nxt  = 1'b1;
        end
      end
      S_OPEN: begin
        // A pass in the last open cycle still counts as a pass.
        if (pass_rise) begin
          state_nxt = S_HOLD;
          event_nxt = 1'b1;
        end else if (timer == TW'(OPEN_TIMEOUT - 1)) begin
          state_nxt = S_HOLD;
        end
      end
      // Leaving DENY only after the car is gone refuses each car once.
      S_DENY:  if (!arrive) state_nxt = S_IDLE;
      S_HOLD:  if (hold_cnt == HW'(CLOSE_HOLD - 1)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      timer       <= '0;
      hold_cnt    <= '0;
      cls         <= 1'b0;
      event_pulse <= 1'b0;
      event_uni   <= 1'b0;
      deny        <= 1'b0;
    end else begin
      state       <= state_nxt;
      event_pulse <= event_nxt;
      event_uni   <= event_nxt & cls;
      deny        <= deny_nxt;
      if (state == S_CHECK) begin
        cls   <= badge;
        timer <= '0;
      end else if (state == S_OPEN && timer != TW'(OPEN_TIMEOUT)) begin
        timer <= timer + 1'b1;
      end
      if (state != S_HOLD) begin
        hold_cnt <= '0;
      end else if (hold_cnt != HW'(CLOSE_HOLD)) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  assign barrier = (state == S_OPEN);
endmodule

module parking_gate_ctrl #(
  parameter int DEBOUNCE     = 4,
  parameter int OPEN_TIMEOUT = 200,
  parameter int CLOSE_HOLD   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       car_at_entry,
  input  logic       uni_badge_entry,
  input  logic       pass_entry,
  input  logic       car_at_exit,
  input  logic       uni_badge_exit,
  input  logic       pass_exit,
  input  logic       uni_is_vacated_space,
  input  logic       is_vacated_space,
  input  logic [8:0] uni_parked_car,
  input  logic [8:0] parked_car,
  output logic       car_entered,
  output logic       is_uni_car_entered,
  output logic       car_exited,
  output logic       is_uni_car_exited,
  output logic       barrier_entry,
  output logic       barrier_exit,
  output logic       deny_entry,
  output logic       deny_exit
);
  logic arrive_entry_deb;
  logic pass_entry_deb;
  logic arrive_exit_deb;
  logic pass_exit_deb;
  logic pass_entry_prev;
  logic pass_exit_prev;
  logic pass_entry_rise;
  logic pass_exit_rise;

  parking_gate_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_arrive_entry (
    .clk(clk), .reset(reset), .sample(car_at_entry), .level(arrive_entry_deb)
  );
  parking_gate_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_pass_entry (
    .clk(clk), .reset(reset), .sample(pass_entry), .level(pass_entry_deb)
  );
  parking_gate_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_arrive_exit (
    .clk(clk), .reset(reset), .sample(car_at_exit), .level(arrive_exit_deb)
  );
  parking_gate_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_pass_exit (
    .clk(clk), .reset(reset), .sample(pass_exit), .level(pass_exit_deb)
  );

  // Rise flags: a sensor held high produces one pass, never a stream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pass_entry_prev <= 1'b0;
      pass_exit_prev  <= 1'b0;
    end else begin
      pass_entry_prev <= pass_entry_deb;
      pass_exit_prev  <= pass_exit_deb;
    end
  end

  assign pass_entry_rise = pass_entry_deb & ~pass_entry_prev;
  assign pass_exit_rise  = pass_exit_deb & ~pass_exit_prev;

  parking_gate_fsm #(.OPEN_TIMEOUT(OPEN_TIMEOUT), .CLOSE_HOLD(CLOSE_HOLD)) u_entry (
    .clk        (clk),
    .reset      (reset),
    .arrive     (arrive_entry_deb),
    .pass_rise  (pass_entry_rise),
    .badge      (uni_badge_entry),
    .grant_uni  (uni_is_vacated_space),
    .grant_free (is_vacated_space),
    .barrier    (barrier_entry),
    .event_pulse(car_entered),
    .event_uni  (is_uni_car_entered),
    .deny       (deny_entry)
  );

  // Exit is allowed only if the counter has a car of that class parked.
  parking_gate_fsm #(.OPEN_TIMEOUT(OPEN_TIMEOUT), .CLOSE_HOLD(CLOSE_HOLD)) u_exit (
    .clk        (clk),
    .reset      (reset),
    .arrive     (arrive_exit_deb),
    .pass_rise  (pass_exit_rise),
    .badge      (uni_badge_exit),
    .grant_uni  (|uni_parked_car),
    .grant_free (|parked_car),
    .barrier    (barrier_exit),
    .event_pulse(car_exited),
    .event_uni  (is_uni_car_exited),
    .deny       (deny_exit)
  );
endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Testbench for parking_gate_ctrl (DEBOUNCE=4, OPEN_TIMEOUT=200, CLOSE_HOLD=8).
// Output word layout: {barrier_entry, barrier_exit, car_entered,
// is_uni_car_entered, car_exited, is_uni_car_exited, deny_entry, deny_exit}.
// Scoreboard entries are {cycle[15:0], outputs[7:0]}; a record is produced
// whenever a barrier changes or any strobe/class bit is high.
module tb_parking_gate_ctrl;
  logic       clk;
  logic       reset;
  logic       car_at_entry;
  logic       uni_badge_entry;
  logic       pass_entry;
  logic       car_at_exit;
  logic       uni_badge_exit;
  logic       pass_exit;
  logic       uni_is_vacated_space;
  logic       is_vacated_space;
  logic [8:0] uni_parked_car;
  logic [8:0] parked_car;
  logic       car_entered;
  logic       is_uni_car_entered;
  logic       car_exited;
  logic       is_uni_car_exited;
  logic       barrier_entry;
  logic       barrier_exit;
  logic       deny_entry;
  logic       deny_exit;

  parking_gate_ctrl #(.DEBOUNCE(4), .OPEN_TIMEOUT(200), .CLOSE_HOLD(8)) dut (
    .clk                 (clk),
    .reset               (reset),
    .car_at_entry        (car_at_entry),
    .uni_badge_entry     (uni_badge_entry),
    .pass_entry          (pass_entry),
    .car_at_exit         (car_at_exit),
    .uni_badge_exit      (uni_badge_exit),
    .pass_exit           (pass_exit),
    .uni_is_vacated_space(uni_is_vacated_space),
    .is_vacated_space    (is_vacated_space),
    .uni_parked_car      (uni_parked_car),
    .parked_car          (parked_car),
    .car_entered         (car_entered),
    .is_uni_car_entered  (is_uni_car_entered),
    .car_exited          (car_exited),
    .is_uni_car_exited   (is_uni_car_exited),
    .barrier_entry       (barrier_entry),
    .barrier_exit        (barrier_exit),
    .deny_entry          (deny_entry),
    .deny_exit           (deny_exit)
  );

  // ---------------- clock / cycle counter ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [23:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  outs_now;
  logic [7:0]  outs_prev = 8'h00;

  assign outs_now = {barrier_entry, barrier_exit, car_entered, is_uni_car_entered,
                     car_exited, is_uni_car_exited, deny_entry, deny_exit};

  task automatic push(input int t, input logic [7:0] o);
    logic [15:0] tt;
    tt = 16'(t);
    exp_q.push_back({tt, o});
  endtask

  task automatic check_now(input string name, input logic [7:0] exp_o);
    checks++;
    if (outs_now !== exp_o) begin
      errors++;
      $display("FAIL %s cycle %0d got %02h expected %02h", name, cyc, outs_now, exp_o);
    end
  endtask

  // Monitor: outputs are all registered or state-decoded, so the falling
  // edge is a stable point to observe them.
  always @(negedge clk) begin
    logic [23:0] got;
    logic [23:0] e;
    got = {16'(cyc), outs_now};
    if ((outs_now[7:6] != outs_prev[7:6]) || (|outs_now[5:0])) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cycle %0d got %02h expected none", cyc, outs_now);
      end else begin
        e = exp_q.pop_front();
        if (e !== got) begin
          errors++;
          $display("FAIL event got cycle %0d outs %02h expected cycle %0d outs %02h",
                   got[23:8], got[7:0], e[23:8], e[7:0]);
        end
      end
    end
    outs_prev = outs_now;
  end

  // ---------------- driver helpers ----------------
  task automatic go_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic sensors_low();
    car_at_entry    = 1'b0;
    uni_badge_entry = 1'b0;
    pass_entry      = 1'b0;
    car_at_exit     = 1'b0;
    uni_badge_exit  = 1'b0;
    pass_exit       = 1'b0;
  endtask

  task automatic feedback(input logic uv, input logic v, input int up, input int p);
    uni_is_vacated_space = uv;
    is_vacated_space     = v;
    uni_parked_car       = 9'(up);
    parked_car           = 9'(p);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int b;
    // Reset held with every sensor high: nothing may move.
    reset           = 1'b0;
    car_at_entry    = 1'b1;
    uni_badge_entry = 1'b1;
    pass_entry      = 1'b1;
    car_at_exit     = 1'b1;
    uni_badge_exit  = 1'b1;
    pass_exit       = 1'b1;
    feedback(1'b1, 1'b1, 0, 0);
    repeat (3) begin
      @(negedge clk);
      check_now("reset_hold", 8'h00);
    end

    // Release: uni entry granted, uni exit refused (no uni car parked).
    // Barrier then stays open for exactly 200 cycles (pass already high).
    @(negedge clk);
    b = cyc;
    reset = 1'b1;
    push(b + 6, 8'h81);
    push(b + 206, 8'h00);
    go_to(b + 10);
    sensors_low();
    feedback(1'b0, 1'b0, 0, 0);
    go_to(b + 230);

    // Free entry with a pass; re-arrival during the close hold is ignored.
    b = cyc;
    feedback(1'b0, 1'b1, 0, 0);
    car_at_entry = 1'b1;
    push(b + 6, 8'h80);
    push(b + 11, 8'h20);
    go_to(b + 6);
    pass_entry = 1'b1;
    go_to(b + 8);
    car_at_entry = 1'b0;
    go_to(b + 12);
    pass_entry   = 1'b0;
    car_at_entry = 1'b1;
    go_to(b + 17);
    car_at_entry = 1'b0;
    go_to(b + 30);

    // Uni entry refused: one deny per car, new deny after re-arrival.
    b = cyc;
    feedback(1'b0, 1'b1, 0, 0);
    uni_badge_entry = 1'b1;
    car_at_entry    = 1'b1;
    push(b + 6, 8'h02);
    push(b + 31, 8'h02);
    go_to(b + 20);
    car_at_entry = 1'b0;
    go_to(b + 25);
    car_at_entry = 1'b1;
    go_to(b + 35);
    sensors_low();
    go_to(b + 45);

    // Uni exit with no uni car parked is refused even though free cars are.
    b = cyc;
    feedback(1'b0, 1'b0, 0, 5);
    uni_badge_exit = 1'b1;
    car_at_exit    = 1'b1;
    push(b + 6, 8'h01);
    go_to(b + 10);
    sensors_low();
    go_to(b + 20);

    // Glitches: 3-cycle arrival and 3-cycle pass do nothing; vacancy loss
    // while open does not revoke the grant; a real pass then closes it.
    b = cyc;
    feedback(1'b0, 1'b1, 0, 0);
    car_at_entry = 1'b1;
    push(b + 16, 8'h80);
    push(b + 35, 8'h20);
    go_to(b + 3);
    car_at_entry = 1'b0;
    go_to(b + 10);
    car_at_entry = 1'b1;
    go_to(b + 18);
    is_vacated_space = 1'b0;
    go_to(b + 20);
    pass_entry = 1'b1;
    go_to(b + 23);
    pass_entry = 1'b0;
    go_to(b + 25);
    car_at_entry = 1'b0;
    go_to(b + 30);
    pass_entry = 1'b1;
    go_to(b + 36);
    pass_entry = 1'b0;
    go_to(b + 50);

    // Concurrent passes: uni entry and free exit in the same cycle. The
    // entry badge drops while open; the latched class must survive.
    b = cyc;
    feedback(1'b1, 1'b0, 0, 3);
    uni_badge_entry = 1'b1;
    uni_badge_exit  = 1'b0;
    car_at_entry    = 1'b1;
    car_at_exit     = 1'b1;
    push(b + 6, 8'hC0);
    push(b + 15, 8'h38);
    go_to(b + 8);
    uni_badge_entry      = 1'b0;
    uni_is_vacated_space = 1'b0;
    go_to(b + 10);
    pass_entry = 1'b1;
    pass_exit  = 1'b1;
    go_to(b + 12);
    car_at_entry = 1'b0;
    car_at_exit  = 1'b0;
    go_to(b + 16);
    sensors_low();
    go_to(b + 30);

    // Reset while both barriers are open: immediate drop, no pulses.
    b = cyc;
    feedback(1'b0, 1'b1, 1, 0);
    uni_badge_entry = 1'b0;
    uni_badge_exit  = 1'b1;
    car_at_entry    = 1'b1;
    car_at_exit     = 1'b1;
    push(b + 6, 8'hC0);
    push(b + 13, 8'h00);
    go_to(b + 10);
    pass_entry = 1'b1;
    pass_exit  = 1'b1;
    go_to(b + 12);
    #2;
    reset = 1'b0;
    #1;
    check_now("async_reset", 8'h00);
    sensors_low();
    go_to(b + 20);
    reset = 1'b1;
    go_to(b + 30);

    // Every expected event must have been seen.
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events got %0d left expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
